// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiplier/divider result path.
// Holds the op-type encodings, the default half-result width and the
// width of one queued result entry {op, dz, result}.
package muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int unsigned MD_W       = 32;
    localparam int unsigned MD_ENTRY_W = 2 * MD_W + 2;

endpackage

// File: rtl/muldiv_fifo.sv
// Generic synchronous FIFO.
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   push_i, wdata_i   write request and data (ignored when full unless popping)
//   pop_i             read request (ignored when empty)
//   rdata_o           head entry, read from the storage registers
//   full_o, empty_o   occupancy flags
//   count_o           entries held
module muldiv_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 66
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [DW-1:0]              wdata_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic          do_push;
    logic          do_pop;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign count_o = wr_q - rd_q;
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (count_o == (AW + 1)'(DEPTH));
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer next-state.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW + 1)'(1);
        if (do_pop)  rd_d = rd_q + (AW + 1)'(1);
    end

    // Pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage; cleared on reset so the head reads as zero when empty after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/muldiv_result_buffer.sv
// Result buffer behind the signed multiplier/divider.
// Captures one result per rising edge of the divider's valid level, tags it
// with the op type latched at start, and queues it for a valid/ready consumer.
// Optional feature macro: DIVZERO_DET_EN (per-entry divide-by-zero flag).
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   start, muordi       start strobe and op type (1 = divide, 0 = multiply)
//   opera1              divisor, sampled at start (divide-by-zero detection only)
//   result, valid       2W-bit result and its done level
//   out_valid/out_ready consumer handshake on the FIFO head
//   out_op/out_hi/out_lo/out_dz  head entry fields
//   count               entries held
//   overflow            sticky: a result was dropped on a full FIFO
module muldiv_result_buffer
    import muldiv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = MD_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    muordi,
    input  logic [W-1:0]            opera1,
    input  logic [2*W-1:0]          result,
    input  logic                    valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_op,
    output logic [W-1:0]            out_hi,
    output logic [W-1:0]            out_lo,
    output logic                    out_dz,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int unsigned EW = MD_ENTRY_W - 2 * MD_W + 2 * W;

    logic          op_q, op_d;
    logic          valid_q;
    logic          overflow_q, overflow_d;
    logic          push_c;
    logic          pop_c;
    logic          dz_c;
    logic          full_c;
    logic          empty_c;
    logic [EW-1:0] wentry_c;
    logic [EW-1:0] rentry_c;

`ifdef DIVZERO_DET_EN
    logic [W-1:0]  opd_q, opd_d;

    // Divisor is taken from the same start as the op tag.
    always_comb begin
        opd_d = opd_q;
        if (start) opd_d = opera1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) opd_q <= '0;
        else        opd_q <= opd_d;
    end

    assign dz_c = (op_q == OP_DIV) && (opd_q == '0);
`else
    logic unused_opera1_c;
    assign unused_opera1_c = ^opera1;
    assign dz_c            = 1'b0;
`endif

    // Capture on the rising edge of valid; a held level pushes once.
    assign push_c = valid && !valid_q;
    assign pop_c  = out_valid && out_ready;

    // Divide-by-zero entries carry a zeroed result.
    assign wentry_c = dz_c ? {op_q, 1'b1, (2 * W)'(0)} : {op_q, dz_c, result};

    always_comb begin
        op_d       = op_q;
        overflow_d = overflow_q;
        if (start) op_d = muordi;
        if (push_c && full_c && !pop_c) overflow_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q       <= OP_MUL;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            valid_q    <= valid;
            overflow_q <= overflow_d;
        end
    end

    muldiv_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_c),
        .wdata_i (wentry_c),
        .pop_i   (pop_c),
        .rdata_o (rentry_c),
        .full_o  (full_c),
        .empty_o (empty_c),
        .count_o (count)
    );

    assign out_valid = !empty_c;
    assign out_op    = rentry_c[EW-1];
    assign out_dz    = rentry_c[EW-2];
    assign out_hi    = rentry_c[2*W-1:W];
    assign out_lo    = rentry_c[W-1:0];
    assign overflow  = overflow_q;

endmodule
